// File: rtl/dmi_pkg.sv
// dmi_pkg: shared encodings for the DMI TileLink initiator.
package dmi_pkg;

    // Debug-transport command opcodes
    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // DTM-style status codes
    localparam logic [1:0] STATUS_OK     = 2'd0;
    localparam logic [1:0] STATUS_FAILED = 2'd2;
    localparam logic [1:0] STATUS_BUSY   = 2'd3;

    // TileLink opcodes used on the A and D channels
    localparam logic [2:0] TL_GET      = 3'd4;
    localparam logic [2:0] TL_PUT_FULL = 3'd0;
    localparam logic [2:0] TL_ACK      = 3'd0;
    localparam logic [2:0] TL_ACK_DATA = 3'd1;

    // Initiator FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dmi_state_e;

endpackage

// File: rtl/dmi_init_timer.sv
// dmi_init_timer: saturating transaction timeout counter for dmi_initiator.
module dmi_init_timer
    import dmi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Count cycles spent in flight; cleared when a new request is launched
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = run && (count == CNT_MAX);

endmodule

// File: rtl/dmi_initiator.sv
// dmi_initiator: turns DTM commands into single DMI TileLink transactions
// and reports DTM-style sticky status.
// Optional build macro: DMI_INITIATOR_TIMEOUT_EN adds a REQ/WAIT timeout.
module dmi_initiator
    import dmi_pkg::*;
#(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              dmi_reset,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        sticky_status,
    output logic              dmi_a_valid,
    input  logic              dmi_a_ready,
    output logic [2:0]        dmi_a_opcode,
    output logic [ADDR_W-1:0] dmi_a_address,
    output logic [DATA_W-1:0] dmi_a_data,
    input  logic              dmi_d_valid,
    output logic              dmi_d_ready,
    input  logic [2:0]        dmi_d_opcode,
    input  logic [DATA_W-1:0] dmi_d_data
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [1:0] sticky_next;
    logic       is_read;
    logic       a_fire_c;
    logic       d_fire_c;
    logic       resp_bad_c;
    logic       cmd_rw_c;
    logic       timeout_c;
    logic       capture_c;
    logic       fail_c;
    logic       busy_c;
    logic       load_cmd_c;

    assign a_fire_c   = dmi_a_valid && dmi_a_ready;
    assign d_fire_c   = dmi_d_valid && dmi_d_ready;
    assign resp_bad_c = dmi_d_opcode != (is_read ? TL_ACK_DATA : TL_ACK);
    assign cmd_rw_c   = (cmd_op == OP_READ) || (cmd_op == OP_WRITE);
    assign busy_c     = cmd_valid && (state != S_IDLE);

`ifdef DMI_INITIATOR_TIMEOUT_EN
    logic in_flight_c;
    assign in_flight_c = (state == S_REQ) || (state == S_WAIT);

    dmi_init_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (load_cmd_c),
        .run       (in_flight_c),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state, capture decisions and sticky status update
    always_comb begin
        state_next  = state;
        load_cmd_c  = 1'b0;
        capture_c   = 1'b0;
        fail_c      = 1'b0;
        sticky_next = sticky_status;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ((sticky_status != STATUS_OK) || !cmd_rw_c) begin
                        state_next = S_RESP;
                    end else begin
                        load_cmd_c = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (timeout_c) begin
                    fail_c     = 1'b1;
                    state_next = S_RESP;
                end else if (a_fire_c) begin
                    if (d_fire_c) begin
                        capture_c  = 1'b1;
                        fail_c     = resp_bad_c;
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (timeout_c) begin
                    fail_c     = 1'b1;
                    state_next = S_RESP;
                end else if (d_fire_c) begin
                    capture_c  = 1'b1;
                    fail_c     = resp_bad_c;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // First error wins; an explicit clear overrides any same-cycle error
        if (sticky_status == STATUS_OK) begin
            if (fail_c) begin
                sticky_next = STATUS_FAILED;
            end else if (busy_c) begin
                sticky_next = STATUS_BUSY;
            end
        end
        if (dmi_reset) begin
            sticky_next = STATUS_OK;
        end
    end

    // State, registered outputs and latched request fields
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            sticky_status <= STATUS_OK;
            is_read       <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_status    <= STATUS_OK;
            rsp_data      <= '0;
            dmi_a_valid   <= 1'b0;
            dmi_d_ready   <= 1'b0;
            dmi_a_opcode  <= '0;
            dmi_a_address <= '0;
            dmi_a_data    <= '0;
        end else begin
            state         <= state_next;
            sticky_status <= sticky_next;
            dmi_a_valid   <= (state_next == S_REQ);
            dmi_d_ready   <= (state_next == S_REQ) || (state_next == S_WAIT);
            rsp_valid     <= (state_next == S_RESP);
            rsp_status    <= (state_next == S_RESP) ? sticky_next : STATUS_OK;
            if (load_cmd_c) begin
                is_read       <= (cmd_op == OP_READ);
                dmi_a_opcode  <= (cmd_op == OP_READ) ? TL_GET : TL_PUT_FULL;
                dmi_a_address <= cmd_addr;
                dmi_a_data    <= (cmd_op == OP_READ) ? '0 : cmd_data;
            end
            if (capture_c && is_read && !resp_bad_c) begin
                rsp_data <= dmi_d_data;
            end
        end
    end

endmodule

// File: doc/dmi_initiator.md
# dmi_initiator

Requester end of the DMI TileLink link: accepts debug-transport commands (read, write, nop) and turns each into exactly one DMI A-channel request. It then waits for the D-channel response and returns the data plus a RISC-V-DTM-style status. Sticky busy/failed errors block further DMI traffic until cleared. The block sits between the JTAG DTM capture/update logic and the debug module's DMI responder.

## Interface
- ADDR_W, 7: DMI address width
- DATA_W, 32: DMI data width
- TIMEOUT_CYCLES, 255: cycles in REQ+WAIT before a transaction is failed (timeout build only)

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  single-cycle command strobe; no ready
- cmd_op  in  2  0 nop, 1 read, 2 write, 3 reserved (treated as nop)
- cmd_addr  in  ADDR_W  DMI address
- cmd_data  in  DATA_W  write data
- dmi_reset  in  1  synchronous clear of sticky status
- rsp_valid  out  1  one-cycle completion pulse
- rsp_status  out  2  0 ok, 2 failed, 3 busy
- rsp_data  out  DATA_W  last captured read data
- sticky_status  out  2  current sticky error
- dmi_a_valid  out  1  A request valid
- dmi_a_ready  in  1  A request ready
- dmi_a_opcode  out  3  4 Get, 0 PutFullData
- dmi_a_address  out  ADDR_W  request address
- dmi_a_data  out  DATA_W  request data (0 for Get)
- dmi_d_valid  in  1  D response valid
- dmi_d_ready  out  1  D response ready
- dmi_d_opcode  in  3  1 AccessAckData, 0 AccessAck
- dmi_d_data  in  DATA_W  response data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. All outputs reset to 0; the FSM resets to IDLE.
- IDLE with cmd_valid:
  - If sticky is nonzero, or the op is nop/reserved: go to RESP with no DMI traffic.
  - Otherwise: latch op, addr and data, then go to REQ.
- REQ: dmi_a_valid=1 and dmi_d_ready=1. dmi_d_ready is driven from state only, never from dmi_a_ready; the responder ties a_ready to d_ready.
  - A fire and D fire in the same cycle: capture the response and go to RESP.
  - A fire alone: go to WAIT.
  - D beat with no A fire: discarded.
- WAIT: dmi_d_ready=1. A D fire captures the response and goes to RESP.
- Response check: the expected d_opcode is 1 for a read and 0 for a write. A mismatch sets sticky to failed (2). A read that passes the check loads rsp_data from dmi_d_data.
- RESP: rsp_valid=1 for one cycle, rsp_status = sticky value after this transaction's update; then return to IDLE.
- cmd_valid outside IDLE: the command is dropped and sticky is set to busy (3) unless it is already nonzero.
- Precedence: the first error wins; sticky is never overwritten by a different nonzero code.
- dmi_reset clears sticky to 0. If it coincides with an error event, the clear wins. It never aborts an in-flight transaction.
- Reset mid-transaction: asynchronous return to IDLE, dmi_a_valid drops immediately, no response is issued.

## Timing
- Read/write with a combinational responder: cmd_valid at t → dmi_a_valid at t+1 (A and D fire) → rsp_valid at t+2.
- Nop or sticky-blocked command: cmd_valid at t → rsp_valid at t+1.
- The earliest next accepted command is the cycle after rsp_valid.
- A-channel fields are stable from REQ entry until the A fire.

## Configuration
- DMI_INITIATOR_TIMEOUT_EN defined:
  - A counter (width clog2(TIMEOUT_CYCLES+1)) clears on REQ entry and increments each cycle in REQ/WAIT.
  - When the count equals TIMEOUT_CYCLES: set sticky to failed, go to RESP, drop dmi_a_valid, and discard any late D beat.
- Undefined: no counter; the block waits indefinitely.

## Structure
- Package dmi_pkg holds:
  - the op encodings
  - the status encodings (OK=0, FAILED=2, BUSY=3)
  - the TL opcodes (GET=4, PUT_FULL=0, ACK=0, ACK_DATA=1)
  - the FSM state enum
- Sub-module dmi_init_timer holds the timeout counter; it is instantiated only under DMI_INITIATOR_TIMEOUT_EN.

## Test plan
- Write addr 0x10, data 0x1 against a combinational responder → one A fire with opcode 0, address 0x10, data 0x1; rsp_valid at t+2 with status 0.
- Read addr 0x11 with the responder returning 0x118380 → opcode 4 issued; rsp_data=0x118380, status 0.
- Hold dmi_a_ready low 3 cycles, then issue a second cmd_valid during REQ → sticky=3, first transaction completes with status 3, next read gets rsp_valid at t+1 with status 3 and no A fire; after dmi_reset, reads resume with status 0.
- Read returning d_opcode 0 → status 2, rsp_data unchanged.
- Timeout build with TIMEOUT_CYCLES=4 and dmi_a_ready stuck low → a_valid drops after 4 cycles, status 2; non-timeout build stays in REQ.
- Assert reset while in WAIT → outputs 0, no rsp_valid, and the next command runs normally.
